amci_arbiter: RTL and testbench

//  Round-robin arbiter letting NUM_CH AMCI controllers share one AXI4-Lite master FSM.

---
 rtl/amci_arbiter_if.sv | 30 +++
 rtl/amci_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_amci_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amci_arbiter_if.sv
// AMCI arbiter bus bundle: packed client-side and master-side AMCI buses.
// The arbiter connects through the slave modport; the environment driving
// clients and the shared master uses the master modport.
interface amci_arbiter_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CH         = 4
);
    localparam int MW = 2 * AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 2;
    localparam int SW = AXI_DATA_WIDTH + 6;

    logic [NUM_CH*MW-1:0] S_AMCI_MOSI;
    logic [NUM_CH*SW-1:0] S_AMCI_MISO;
    logic [MW-1:0]        M_AMCI_MOSI;
    logic [SW-1:0]        M_AMCI_MISO;

    modport slave (
        input  S_AMCI_MOSI,
        input  M_AMCI_MISO,
        output S_AMCI_MISO,
        output M_AMCI_MOSI
    );

    modport master (
        output S_AMCI_MOSI,
        output M_AMCI_MISO,
        input  S_AMCI_MISO,
        input  M_AMCI_MOSI
    );
endinterface

// File: rtl/amci_arbiter.sv
// Round-robin arbiter sharing one AMCI master among NUM_CH client ports.
// Write and read paths are captured, arbitrated and completed independently.
// MOSI packing (LSB up): waddr, wdata, raddr, write, read.
// MISO packing (LSB up): rdata, widle, ridle, wresp[1:0], rresp[1:0].
module amci_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CH         = 4
) (
    input logic           CLK,
    input logic           RESETN,
    amci_arbiter_if.slave bus
);
    localparam int          DW  = AXI_DATA_WIDTH;
    localparam int          AW  = AXI_ADDR_WIDTH;
    localparam int          MW  = 2 * AW + DW + 2;
    localparam int          SW  = DW + 6;
    localparam int          PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NCH = NUM_CH;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_ISSUE = 2'd1;
    localparam logic [1:0] W_BUSY  = 2'd2;
    localparam logic [1:0] W_DONE  = 2'd3;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_BUSY  = 2'd2;
    localparam logic [1:0] R_DONE  = 2'd3;

    // client-side request fields
    logic [AW-1:0]     s_waddr [NUM_CH];
    logic [DW-1:0]     s_wdata [NUM_CH];
    logic [AW-1:0]     s_raddr [NUM_CH];
    logic [NUM_CH-1:0] s_write;
    logic [NUM_CH-1:0] s_read;

    // shared-master response fields
    logic          m_widle;
    logic          m_ridle;
    logic [1:0]    m_wresp;
    logic [1:0]    m_rresp;
    logic [DW-1:0] m_rdata;

    // per-channel captured requests and returned responses
    logic [NUM_CH-1:0] wpend;
    logic [NUM_CH-1:0] rpend;
    logic [AW-1:0]     waddr_q [NUM_CH];
    logic [DW-1:0]     wdata_q [NUM_CH];
    logic [AW-1:0]     raddr_q [NUM_CH];
    logic [1:0]        wresp_q [NUM_CH];
    logic [1:0]        rresp_q [NUM_CH];
    logic [DW-1:0]     rdata_q [NUM_CH];

    // path state and registered master-side request
    logic [1:0]    wstate;
    logic [1:0]    rstate;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wgnt;
    logic [PW-1:0] rgnt;
    logic          m_write_q;
    logic          m_read_q;
    logic [AW-1:0] m_waddr_q;
    logic [DW-1:0] m_wdata_q;
    logic [AW-1:0] m_raddr_q;

    logic [PW:0]   w_pick;
    logic [PW:0]   r_pick;

    // First pending channel after ptr, wrapping; MSB flags that one was found.
    function automatic logic [PW:0] rr_pick(input logic [NUM_CH-1:0] pend,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0] res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!res[PW] && pend[PW'(cand)]) res = {1'b1, PW'(cand)};
        end
        return res;
    endfunction

    assign m_rdata = bus.M_AMCI_MISO[DW-1:0];
    assign m_widle = bus.M_AMCI_MISO[DW];
    assign m_ridle = bus.M_AMCI_MISO[DW+1];
    assign m_wresp = bus.M_AMCI_MISO[DW+2 +: 2];
    assign m_rresp = bus.M_AMCI_MISO[DW+4 +: 2];

    assign bus.M_AMCI_MOSI = {m_read_q, m_write_q, m_raddr_q, m_wdata_q, m_waddr_q};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign s_waddr[ch] = bus.S_AMCI_MOSI[ch*MW +: AW];
        assign s_wdata[ch] = bus.S_AMCI_MOSI[ch*MW + AW +: DW];
        assign s_raddr[ch] = bus.S_AMCI_MOSI[ch*MW + AW + DW +: AW];
        assign s_write[ch] = bus.S_AMCI_MOSI[ch*MW + 2*AW + DW];
        assign s_read[ch]  = bus.S_AMCI_MOSI[ch*MW + 2*AW + DW + 1];
        assign bus.S_AMCI_MISO[ch*SW +: SW] =
            {rresp_q[ch], wresp_q[ch], ~rpend[ch], ~wpend[ch], rdata_q[ch]};
    end

    assign w_pick = rr_pick(wpend, wptr);
    assign r_pick = rr_pick(rpend, rptr);

    // Write path: capture client requests, grant round-robin, run one master write.
    // A channel's set (only while not pending) and clear (only while pending) never collide.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wstate    <= W_IDLE;
            wptr      <= PW'(NUM_CH - 1);
            wgnt      <= '0;
            wpend     <= '0;
            m_write_q <= 1'b0;
            m_waddr_q <= '0;
            m_wdata_q <= '0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                waddr_q[ch] <= '0;
                wdata_q[ch] <= '0;
                wresp_q[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (s_write[ch] && !wpend[ch]) begin
                    wpend[ch]   <= 1'b1;
                    waddr_q[ch] <= s_waddr[ch];
                    wdata_q[ch] <= s_wdata[ch];
                end
            end
            case (wstate)
                W_IDLE: begin
                    if (w_pick[PW] && m_widle) begin
                        wgnt      <= w_pick[PW-1:0];
                        m_waddr_q <= waddr_q[w_pick[PW-1:0]];
                        m_wdata_q <= wdata_q[w_pick[PW-1:0]];
                        m_write_q <= 1'b1;
                        wstate    <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    m_write_q <= 1'b0;
                    wstate    <= W_BUSY;
                end
                W_BUSY: begin
                    if (!m_widle) wstate <= W_DONE;
                end
                W_DONE: begin
                    if (m_widle) begin
                        wresp_q[wgnt] <= m_wresp;
                        wpend[wgnt]   <= 1'b0;
                        wptr          <= wgnt;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read path: same flow as writes, returning rresp and rdata to the granted client.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rstate    <= R_IDLE;
            rptr      <= PW'(NUM_CH - 1);
            rgnt      <= '0;
            rpend     <= '0;
            m_read_q  <= 1'b0;
            m_raddr_q <= '0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                raddr_q[ch] <= '0;
                rresp_q[ch] <= '0;
                rdata_q[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (s_read[ch] && !rpend[ch]) begin
                    rpend[ch]   <= 1'b1;
                    raddr_q[ch] <= s_raddr[ch];
                end
            end
            case (rstate)
                R_IDLE: begin
                    if (r_pick[PW] && m_ridle) begin
                        rgnt      <= r_pick[PW-1:0];
                        m_raddr_q <= raddr_q[r_pick[PW-1:0]];
                        m_read_q  <= 1'b1;
                        rstate    <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    m_read_q <= 1'b0;
                    rstate   <= R_BUSY;
                end
                R_BUSY: begin
                    if (!m_ridle) rstate <= R_DONE;
                end
                R_DONE: begin
                    if (m_ridle) begin
                        rresp_q[rgnt] <= m_rresp;
                        rdata_q[rgnt] <= m_rdata;
                        rpend[rgnt]   <= 1'b0;
                        rptr          <= rgnt;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_amci_arbiter.sv
// Self-checking bench for amci_arbiter: directed scenarios plus random client
// traffic against a request-set / last-served reference model and a simple
// AMCI master responder with random latency and responses.
module tb_amci_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 4;
    localparam int MW = 2 * AW + DW + 2;
    localparam int SW = DW + 6;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    amci_arbiter_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_CH(N)) bus_if ();

    amci_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_CH(N)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus_if)
    );

    // stimulus: index 0 = write path, 1 = read path
    logic        pulse  [2][N];
    logic [31:0] s_addr [2][N];
    logic [31:0] s_wdata[N];
    logic        m_idle [2];
    logic [1:0]  m_resp [2];
    logic [31:0] m_rdata;

    always_comb begin
        bus_if.S_AMCI_MOSI = '0;
        for (int ch = 0; ch < N; ch++)
            bus_if.S_AMCI_MOSI[ch*MW +: MW] =
                {pulse[1][ch], pulse[0][ch], s_addr[1][ch], s_wdata[ch], s_addr[0][ch]};
        bus_if.M_AMCI_MISO = {m_resp[1], m_resp[0], m_idle[1], m_idle[0], m_rdata};
    end

    // reference model state
    bit          pend      [2][N];
    bit          pend_prev [2][N];
    logic [31:0] cap_a     [2][N];
    logic [31:0] cap_d     [N];
    logic [1:0]  exp_resp  [2][N];
    logic [31:0] exp_rdata [N];
    int          last      [2];
    bit          busy      [2];
    bit          done_edge [2];
    int          gch       [2];
    int          cnt       [2];
    int          stall     [2];
    int          force_d;
    int          wlog[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] exp_miso(input int ch);
        return {exp_resp[1][ch], exp_resp[0][ch], !pend[1][ch], !pend[0][ch], exp_rdata[ch]};
    endfunction

    // first pending channel after the last served one, from the pre-edge request set
    function automatic int pick(input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last[p] + k) % N;
            if (pend_prev[p][i]) return i;
        end
        return -1;
    endfunction

    function automatic bit quiet();
        for (int p = 0; p < 2; p++) begin
            if (busy[p]) return 1'b0;
            for (int ch = 0; ch < N; ch++) if (pend[p][ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int ch = 0; ch < N; ch++) begin
                pend[p][ch]     = 1'b0;
                exp_resp[p][ch] = 2'd0;
            end
            last[p] = N - 1; busy[p] = 1'b0; done_edge[p] = 1'b0;
            stall[p] = 0; cnt[p] = 0; gch[p] = 0;
            m_idle[p] = 1'b1; m_resp[p] = 2'd0;
        end
        for (int ch = 0; ch < N; ch++) exp_rdata[ch] = '0;
        m_rdata = '0;
    endtask

    task automatic clear_pulses();
        for (int p = 0; p < 2; p++)
            for (int ch = 0; ch < N; ch++) pulse[p][ch] = 1'b0;
    endtask

    task automatic issue_check(input int p);
        logic mw;
        logic [31:0] maddr;
        int g;
        mw    = bus_if.M_AMCI_MOSI[2*AW+DW+p];
        maddr = bus_if.M_AMCI_MOSI[(p == 0 ? 0 : AW + DW) +: AW];
        if (busy[p]) begin
            check($sformatf("p%0d no issue while outstanding", p), mw, 1'b0);
            stall[p] = 0;
        end else begin
            g = pick(p);
            if (mw) begin
                check($sformatf("p%0d issue has pending req", p), g >= 0, 1'b1);
                if (p == 0) wlog.push_back(int'(maddr[2:0]));
                if (g >= 0) begin
                    check($sformatf("p%0d addr ch%0d", p, g), maddr, cap_a[p][g]);
                    if (p == 0)
                        check($sformatf("wdata ch%0d", g), bus_if.M_AMCI_MOSI[AW +: DW], cap_d[g]);
                    busy[p] = 1'b1; gch[p] = g; m_idle[p] = 1'b0;
                    cnt[p] = (force_d != 0) ? force_d : int'($urandom_range(2, 5));
                end
                stall[p] = 0;
            end else if (g >= 0) begin
                stall[p]++;
                check($sformatf("p%0d grant stall", p), stall[p] >= 2, 1'b0);
            end else begin
                stall[p] = 0;
            end
        end
    endtask

    task automatic cycle();
        pend_prev = pend;
        @(posedge CLK);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (done_edge[p]) begin
                pend[p][gch[p]]     = 1'b0;
                exp_resp[p][gch[p]] = m_resp[p];
                if (p == 1) exp_rdata[gch[p]] = m_rdata;
                last[p] = gch[p]; busy[p] = 1'b0; done_edge[p] = 1'b0;
            end
        end
        if (RESETN) begin
            for (int p = 0; p < 2; p++)
                for (int ch = 0; ch < N; ch++)
                    if (pulse[p][ch] && !pend_prev[p][ch]) begin
                        pend[p][ch]  = 1'b1;
                        cap_a[p][ch] = s_addr[p][ch];
                        if (p == 0) cap_d[ch] = s_wdata[ch];
                    end
        end
        for (int ch = 0; ch < N; ch++)
            check($sformatf("s_miso ch%0d", ch), bus_if.S_AMCI_MISO[ch*SW +: SW], exp_miso(ch));
        // shared-master responder: hold idle low for cnt cycles, junk responses meanwhile
        for (int p = 0; p < 2; p++) begin
            if (busy[p] && !done_edge[p]) begin
                cnt[p]--;
                m_resp[p] = 2'($urandom_range(0, 3));
                if (p == 1) m_rdata = $urandom;
                if (cnt[p] == 0) begin
                    m_idle[p] = 1'b1;
                    done_edge[p] = 1'b1;
                end
            end
        end
        for (int p = 0; p < 2; p++) issue_check(p);
    endtask

    task automatic drain();
        int k;
        k = 0;
        clear_pulses();
        while (!quiet() && k < 300) begin
            cycle();
            k++;
        end
        check("drain completes", quiet(), 1'b1);
    endtask

    initial begin
        logic [19:0] order;
        bit found;
        bit resent;
        int k;

        RESETN  = 1'b0;
        force_d = 0;
        clear_pulses();
        for (int p = 0; p < 2; p++)
            for (int ch = 0; ch < N; ch++) s_addr[p][ch] = '0;
        for (int ch = 0; ch < N; ch++) s_wdata[ch] = '0;
        model_reset();
        repeat (3) cycle();
        check("reset m_mosi lo", bus_if.M_AMCI_MOSI[63:0], 64'd0);
        check("reset m_mosi hi", 64'(bus_if.M_AMCI_MOSI[MW-1:64]), 64'd0);
        RESETN = 1'b1;

        // single uncontended write: issue two edges after the client pulse
        pulse[0][0] = 1'b1; s_addr[0][0] = 32'h0000_1000; s_wdata[0] = 32'hA5A5_A5A5;
        cycle();
        check("ch0 widle drops", bus_if.S_AMCI_MISO[DW], 1'b0);
        check("no issue one edge after pulse", bus_if.M_AMCI_MOSI[2*AW+DW], 1'b0);
        clear_pulses();
        cycle();
        check("issue two edges after pulse", bus_if.M_AMCI_MOSI[2*AW+DW], 1'b1);
        check("issue waddr", bus_if.M_AMCI_MOSI[AW-1:0], 32'h0000_1000);
        check("issue wdata", bus_if.M_AMCI_MOSI[AW +: DW], 32'hA5A5_A5A5);
        drain();

        // reset while ch1's write sits in the completion-wait phase
        force_d = 8;
        pulse[0][1] = 1'b1; s_addr[0][1] = 32'h0000_4001; s_wdata[1] = 32'h1111_2222;
        cycle();
        clear_pulses();
        found = 1'b0;
        k = 0;
        while (!found && k < 12) begin
            cycle();
            found = busy[0] && gch[0] == 1;
            k++;
        end
        check("ch1 granted before reset", found, 1'b1);
        repeat (3) cycle();
        RESETN = 1'b0;
        #1;
        model_reset();
        force_d = 0;
        check("mid reset m_write", bus_if.M_AMCI_MOSI[2*AW+DW], 1'b0);
        check("mid reset m_mosi lo", bus_if.M_AMCI_MOSI[63:0], 64'd0);
        for (int ch = 0; ch < N; ch++)
            check($sformatf("mid reset s_miso ch%0d", ch), bus_if.S_AMCI_MISO[ch*SW +: SW], exp_miso(ch));
        repeat (2) cycle();
        RESETN = 1'b1;

        // all four write at once, ch1 re-requests as soon as its idle returns
        wlog.delete();
        for (int ch = 0; ch < N; ch++) begin
            pulse[0][ch]  = 1'b1;
            s_addr[0][ch] = 32'h0000_5000 + 32'(ch);
            s_wdata[ch]   = 32'hC0DE_0000 + 32'(ch);
        end
        cycle();
        clear_pulses();
        resent = 1'b0;
        k = 0;
        while (!(resent && quiet()) && k < 300) begin
            if (!resent && wlog.size() >= 2 && !pend[0][1]) begin
                pulse[0][1] = 1'b1; s_addr[0][1] = 32'h0000_6001; s_wdata[1] = 32'h6666_0001;
                resent = 1'b1;
            end
            cycle();
            clear_pulses();
            k++;
        end
        check("grant count", wlog.size(), 5);
        order = '0;
        for (int i = 0; i < wlog.size() && i < 5; i++) order = {order[15:0], 4'(wlog[i])};
        check("grant order 0,1,2,3,1", order, 20'h01231);

        // random concurrent read/write traffic, including pulses while busy
        for (int c = 0; c < 700; c++) begin
            for (int p = 0; p < 2; p++)
                for (int ch = 0; ch < N; ch++) begin
                    pulse[p][ch]  = ($urandom_range(0, 3) == 0);
                    s_addr[p][ch] = ($urandom & 32'hFFFF_FFF8) | 32'(ch);
                end
            for (int ch = 0; ch < N; ch++) s_wdata[ch] = $urandom;
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
